apb_uart_requester: RTL and testbench

APB requester (initiator) that drives the APB UART completer's bus.
- Accepts simple read/write commands from a local controller through a valid/ready interface.
- Buffers commands in a small FIFO and sequences each one through APB SETUP and ACCESS phases.
- Waits on PREADY under a timeout, then returns one response per command (read data or write completion) through a second valid/ready interface.

---
 rtl/apb_uart_pkg.sv | 32 +++
 rtl/apb_uart_requester_if.sv | 49 ++++
 rtl/apb_cmd_fifo.sv | 50 +++++
 rtl/apb_uart_requester.sv | 160 ++++++++++++++++
 tb/tb_apb_uart_requester.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/apb_uart_pkg.sv
// Shared types for the APB UART requester: FSM state, command bundle,
// and UART register offsets used by callers when building cmd_addr.
package apb_uart_pkg;

  localparam int CMD_ADDR_W  = 12;
  localparam int CMD_WDATA_W = 8;
  localparam int CMD_RDATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } req_state_e;

  typedef struct packed {
    logic                   write;
    logic [CMD_ADDR_W-1:0]  addr;
    logic [CMD_WDATA_W-1:0] wdata;
  } cmd_t;

  localparam logic [3:0] UART_SEL     = 4'h1;
  localparam logic [7:0] UART_RBR_THR = 8'h00;
  localparam logic [7:0] UART_IER     = 8'h04;
  localparam logic [7:0] UART_IIR_FCR = 8'h08;
  localparam logic [7:0] UART_LCR     = 8'h0C;
  localparam logic [7:0] UART_MCR     = 8'h10;
  localparam logic [7:0] UART_LSR     = 8'h14;
  localparam logic [7:0] UART_MSR     = 8'h18;
  localparam logic [7:0] UART_SCR     = 8'h1C;

endpackage

// File: rtl/apb_uart_requester_if.sv
// Command/response valid-ready channels plus the APB requester bus.
// master: the requester; slave: local controller and APB completer side.
interface apb_uart_requester_if
  import apb_uart_pkg::*;
#(
  parameter int ADDR_W  = CMD_ADDR_W,
  parameter int WDATA_W = CMD_WDATA_W,
  parameter int RDATA_W = CMD_RDATA_W
);

  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_write;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [WDATA_W-1:0] cmd_wdata;

  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_write;
  logic [RDATA_W-1:0] rsp_rdata;
  logic               rsp_timeout;

  logic               PSEL;
  logic               PENABLE;
  logic               PWRITE;
  logic [ADDR_W-1:0]  PADDR;
  logic [WDATA_W-1:0] PWDATA;
  logic               PREADY;
  logic [RDATA_W-1:0] PRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_write, rsp_rdata, rsp_timeout,
    input  rsp_ready,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PRDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_write, rsp_rdata, rsp_timeout,
    output rsp_ready,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PRDATA
  );

endinterface

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO, no pass-through; extra pointer MSB tells
// full from empty. Ports: push/wdata/full, pop/rdata/empty.
module apb_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 21
) (
  input  logic         PCLK,
  input  logic         PRESETn,
  input  logic         push,
  input  logic [W-1:0] wdata,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr_q;
  logic [AW:0]  rptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wptr_q[AW-1:0]] <= wdata;
        wptr_q <= wptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/apb_uart_requester.sv
// APB requester: queues commands, runs SETUP/ACCESS with a PREADY
// timeout, returns one response each. Ports: PCLK, PRESETn, busy, bus.
module apb_uart_requester
  import apb_uart_pkg::*;
#(
  parameter int ADDR_W      = CMD_ADDR_W,
  parameter int WDATA_W     = CMD_WDATA_W,
  parameter int RDATA_W     = CMD_RDATA_W,
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic PCLK,
  input  logic PRESETn,
  output logic busy,
  apb_uart_requester_if.master bus
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

  req_state_e state_q, state_d;

  logic               psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic [WDATA_W-1:0] pwdata_q, pwdata_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_write_q, rsp_write_d;
  logic [RDATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic               rsp_tmo_q, rsp_tmo_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  cmd_t push_cmd;
  cmd_t head;
  logic fifo_full;
  logic fifo_empty;
  logic pop;

  assign push_cmd.write = bus.cmd_write;
  assign push_cmd.addr  = bus.cmd_addr;
  assign push_cmd.wdata = bus.cmd_wdata;

  apb_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .W     ($bits(cmd_t))
  ) u_fifo (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .push    (bus.cmd_valid),
    .wdata   (push_cmd),
    .full    (fifo_full),
    .pop     (pop),
    .rdata   (head),
    .empty   (fifo_empty)
  );

  assign bus.cmd_ready   = !fifo_full;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_write   = rsp_write_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_timeout = rsp_tmo_q;
  assign busy = (state_q != IDLE) || !fifo_empty;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_tmo_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_tmo_q   <= rsp_tmo_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_tmo_d   = rsp_tmo_q;
    cnt_d       = cnt_q;
    pop         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          paddr_d   = head.addr;
          pwrite_d  = head.write;
          pwdata_d  = head.write ? head.wdata : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // PREADY wins over the timeout boundary on the same cycle
        if (bus.PREADY) begin
          rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
          rsp_tmo_d   = 1'b0;
          rsp_write_d = pwrite_q;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (cnt_q == CNT_MAX) begin
          rsp_rdata_d = '0;
          rsp_tmo_d   = 1'b1;
          rsp_write_d = pwrite_q;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_uart_requester.sv
// Directed bench for apb_uart_requester with TIMEOUT_CYC=8.
// The APB completer is modelled by PREADY control and a PRDATA source.
module tb_apb_uart_requester;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  logic busy;
  logic echo;
  logic [31:0] prdata_v;
  int checks = 0;
  int errors = 0;
  int acc;

  always #5 PCLK = ~PCLK;

  apb_uart_requester_if bus ();

  apb_uart_requester #(
    .CMD_DEPTH   (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .busy    (busy),
    .bus     (bus)
  );

  // completer read data: either a fixed value or the address echoed back
  always_comb bus.PRDATA = echo ? {20'h0, bus.PADDR} : prdata_v;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic push(input logic w, input logic [11:0] a,
                      input logic [7:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // counts ACCESS cycles until rsp_valid shows, bounded
  task automatic wait_rsp(output int n);
    logic got;
    got = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      if (bus.rsp_valid === 1'b1) got = 1'b1;
      else if (bus.PSEL && bus.PENABLE) n++;
    end
    chk("rsp_wait", 32'(got), 1);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.PREADY    = 1'b0;
    echo          = 1'b0;
    prdata_v      = 32'hDEADBEEF;

    repeat (2) tick();
    chk("rst_outs", 32'({bus.PSEL, bus.PENABLE, bus.PWRITE,
        bus.rsp_valid, bus.rsp_write, bus.rsp_timeout, busy,
        bus.cmd_ready}), 'h01);
    chk("rst_paddr", 32'(bus.PADDR), 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    PRESETn = 1'b1;
    tick();

    // zero-wait write
    bus.PREADY = 1'b1;
    chk("t1_rdy", 32'(bus.cmd_ready), 1);
    push(1'b1, 12'h100, 8'hA5);
    chk("t1_acc", 32'({busy, bus.PSEL}), 'b10);
    tick();
    chk("t1_setup", 32'({bus.PSEL, bus.PENABLE, bus.PWRITE}), 'b101);
    chk("t1_paddr", 32'(bus.PADDR), 'h100);
    chk("t1_pwdata", 32'(bus.PWDATA), 'hA5);
    tick();
    chk("t1_access", 32'({bus.PSEL, bus.PENABLE, bus.rsp_valid}), 'b110);
    chk("t1_pwdata2", 32'(bus.PWDATA), 'hA5);
    tick();
    chk("t1_rsp", 32'({bus.PSEL, bus.PENABLE, bus.rsp_valid,
        bus.rsp_write, bus.rsp_timeout}), 'b00110);
    chk("t1_rdata", bus.rsp_rdata, 0);
    bus.rsp_ready = 1'b1;
    tick();
    chk("t1_done", 32'({bus.rsp_valid, busy, bus.PSEL}), 0);
    chk("t1_paddr_hold", 32'(bus.PADDR), 'h100);

    // read with 3 wait cycles
    bus.PREADY = 1'b0;
    prdata_v = 32'h0000_005A;
    push(1'b0, 12'h104, 8'hFF);
    tick();
    chk("t2_setup", 32'({bus.PSEL, bus.PENABLE, bus.PWRITE}), 'b100);
    chk("t2_pwdata", 32'(bus.PWDATA), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_access", 32'({bus.PSEL, bus.PENABLE, bus.rsp_valid}), 'b110);
      chk("t2_paddr", 32'(bus.PADDR), 'h104);
      if (i == 3) bus.PREADY = 1'b1;
    end
    tick();
    chk("t2_rsp", 32'({bus.PSEL, bus.rsp_valid, bus.rsp_write,
        bus.rsp_timeout}), 'b0100);
    chk("t2_rdata", bus.rsp_rdata, 'h5A);
    tick();
    chk("t2_done", 32'(bus.rsp_valid), 0);

    // timeout, then queued read completes
    bus.PREADY = 1'b0;
    echo = 1'b1;
    bus.rsp_ready = 1'b0;
    push(1'b1, 12'h200, 8'h11);
    push(1'b0, 12'h204, 8'h00);
    wait_rsp(acc);
    chk("t3_acc", 32'(acc), 8);
    chk("t3_tmo", 32'({bus.PSEL, bus.PENABLE, bus.rsp_valid,
        bus.rsp_write, bus.rsp_timeout}), 'b00111);
    chk("t3_rdata", bus.rsp_rdata, 0);
    bus.PREADY = 1'b1;
    bus.rsp_ready = 1'b1;
    wait_rsp(acc);
    chk("t3_acc2", 32'(acc), 1);
    chk("t3_rsp2", 32'({bus.rsp_write, bus.rsp_timeout}), 0);
    chk("t3_rdata2", bus.rsp_rdata, 'h204);
    tick();

    // PREADY exactly on the timeout boundary counts as success
    bus.PREADY = 1'b0;
    push(1'b0, 12'h210, 8'h00);
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t3b_access", 32'({bus.PSEL, bus.PENABLE}), 'b11);
      if (i == 7) bus.PREADY = 1'b1;
    end
    tick();
    chk("t3b_rsp", 32'({bus.rsp_valid, bus.rsp_timeout}), 'b10);
    chk("t3b_rdata", bus.rsp_rdata, 'h210);
    tick();

    // fill FIFO behind a stalled transfer
    bus.PREADY = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t4_rdy", 32'(bus.cmd_ready), 1);
      push(1'b0, 12'(12'h300 + 4 * k), 8'h00);
    end
    chk("t4_full", 32'({bus.cmd_ready, busy}), 'b01);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 12'h3FF;
    tick();
    bus.cmd_valid = 1'b0;
    chk("t4_full2", 32'(bus.cmd_ready), 0);
    bus.PREADY = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(acc);
      chk("t4_rdata", bus.rsp_rdata, 32'(12'h300 + 4 * k));
      chk("t4_tmo", 32'(bus.rsp_timeout), 0);
    end
    tick();
    chk("t4_drain", 32'({busy, bus.cmd_ready, bus.rsp_valid}), 'b010);
    repeat (3) tick();
    chk("t4_no_extra", 32'({busy, bus.PSEL}), 0);

    // response backpressure
    bus.rsp_ready = 1'b0;
    push(1'b0, 12'h400, 8'h00);
    push(1'b1, 12'h408, 8'h77);
    wait_rsp(acc);
    chk("t5_rdata", bus.rsp_rdata, 'h400);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_hold", 32'({bus.rsp_valid, bus.PSEL, bus.PENABLE,
          bus.rsp_write, bus.rsp_timeout, busy}), 'b100001);
      chk("t5_hold_rd", bus.rsp_rdata, 'h400);
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("t5_hs", 32'({bus.rsp_valid, bus.PSEL}), 0);
    tick();
    chk("t5_setup", 32'({bus.PSEL, bus.PENABLE, bus.PWRITE}), 'b101);
    chk("t5_paddr", 32'(bus.PADDR), 'h408);
    chk("t5_pwdata", 32'(bus.PWDATA), 'h77);
    wait_rsp(acc);
    chk("t5_rsp2", 32'({bus.rsp_write, bus.rsp_timeout}), 'b10);
    chk("t5_rdata2", bus.rsp_rdata, 0);
    tick();

    // reset during ACCESS with 3 queued
    bus.PREADY = 1'b0;
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push(1'b1, 12'(12'h500 + 4 * k), 8'(k));
    end
    chk("t6_access", 32'({bus.PSEL, bus.PENABLE, busy}), 'b111);
    #2;
    PRESETn = 1'b0;
    #1;
    chk("t6_rst", 32'({bus.PSEL, bus.PENABLE, bus.rsp_valid, busy,
        bus.cmd_ready}), 'b00001);
    tick();
    PRESETn = 1'b1;
    bus.PREADY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_after", 32'({bus.PSEL, bus.PENABLE, bus.rsp_valid, busy,
          bus.cmd_ready}), 'b00001);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
